ruta_de_datos_seg: RTL

Parametrised, two-stage pipelined datapath. It has a register file of `2**AW` registers, each `W` bits wide. The pipeline has an operand-fetch stage (OF) with B-constant select, and an execute/writeback stage (EX) with a functional unit, D-select and registered status flags. A full-bypass path lets back-to-back dependent microinstructions issue every cycle without stalls. It sits under the control unit in place of the single-cycle datapath, keeps the same FS/select/address control fields, and adds `en`, `valid_in` and `FL` flag-load.

---
 rtl/ruta_de_datos_seg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ruta_de_datos_seg.sv
// Two-stage pipelined datapath: operand fetch with full bypass, then execute/writeback.
// The register file, EX stage and status flags all share one async active-low reset.
module ruta_de_datos_seg #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [3:0]    fs_i,
  input  logic [AW-1:0] addr_d_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic          mb_select_i,
  input  logic          md_select_i,
  input  logic          rw_i,
  input  logic          fl_i,
  input  logic [W-1:0]  const_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  bus_a_o,
  output logic [W-1:0]  bus_b_o,
  output logic [W-1:0]  bus_d_o,
  output logic          valid_ex_o,
  output logic          v_o,
  output logic          z_o,
  output logic          n_o,
  output logic          c_o
);

  localparam int NR = 2 ** AW;

  logic [W-1:0]  rf_q [NR];

  logic          valid_ex_q;
  logic [3:0]    fs_ex_q;
  logic [AW-1:0] addr_d_ex_q;
  logic          rw_ex_q;
  logic          md_ex_q;
  logic          fl_ex_q;
  logic [W-1:0]  data_ex_q;
  logic [W-1:0]  a_ex_q;
  logic [W-1:0]  b_ex_q;
  logic          v_q, z_q, n_q, c_q;

  logic [W-1:0]  a_d, b_d;
  logic          hit_a, hit_b;

  logic [W-1:0]  add_y;
  logic          add_cin;
  logic [W:0]    sum;
  logic [W-1:0]  f;
  logic          f_c, f_v;
  logic [W-1:0]  bus_d;

  // Functional unit: codes 0xxx share one adder, A + Y + cin.
  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    case (fs_ex_q[2:0])
      3'b001:  add_cin = 1'b1;
      3'b010:  add_y = b_ex_q;
      3'b011:  begin add_y = b_ex_q;  add_cin = 1'b1; end
      3'b100:  add_y = ~b_ex_q;
      3'b101:  begin add_y = ~b_ex_q; add_cin = 1'b1; end
      3'b110:  add_y = '1;
      default: add_y = '0;
    endcase
    sum = {1'b0, a_ex_q} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    f   = sum[W-1:0];
    f_c = sum[W];
    f_v = (a_ex_q[W-1] == add_y[W-1]) && (f[W-1] != a_ex_q[W-1]);
    if (fs_ex_q[3]) begin
      f_c = 1'b0;
      f_v = 1'b0;
      case (fs_ex_q[2:0])
        3'b000:  f = a_ex_q & b_ex_q;
        3'b001:  f = a_ex_q | b_ex_q;
        3'b010:  f = a_ex_q ^ b_ex_q;
        3'b011:  f = ~a_ex_q;
        3'b101:  begin f = {1'b0, b_ex_q[W-1:1]}; f_c = b_ex_q[0]; end
        3'b110:  begin f = {b_ex_q[W-2:0], 1'b0}; f_c = b_ex_q[W-1]; end
        default: f = b_ex_q;
      endcase
    end
  end

  assign bus_d = md_ex_q ? data_ex_q : f;

  // Forward the EX result to a dependent op; a bubble in EX never forwards.
  always_comb begin
    hit_a = valid_ex_q && rw_ex_q && (addr_d_ex_q == addr_a_i);
    hit_b = valid_ex_q && rw_ex_q && (addr_d_ex_q == addr_b_i);
    a_d   = hit_a ? bus_d : rf_q[addr_a_i];
    if (mb_select_i)
      b_d = const_i;
    else
      b_d = hit_b ? bus_d : rf_q[addr_b_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
      valid_ex_q  <= 1'b0;
      fs_ex_q     <= '0;
      addr_d_ex_q <= '0;
      rw_ex_q     <= 1'b0;
      md_ex_q     <= 1'b0;
      fl_ex_q     <= 1'b0;
      data_ex_q   <= '0;
      a_ex_q      <= '0;
      b_ex_q      <= '0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
    end else if (en_i) begin
      if (valid_ex_q && rw_ex_q) rf_q[addr_d_ex_q] <= bus_d;
      if (valid_ex_q && fl_ex_q) begin
        v_q <= f_v;
        z_q <= (f == '0);
        n_q <= f[W-1];
        c_q <= f_c;
      end
      valid_ex_q  <= valid_i;
      fs_ex_q     <= fs_i;
      addr_d_ex_q <= addr_d_i;
      rw_ex_q     <= rw_i;
      md_ex_q     <= md_select_i;
      fl_ex_q     <= fl_i;
      data_ex_q   <= data_i;
      a_ex_q      <= a_d;
      b_ex_q      <= b_d;
    end
  end

  assign bus_a_o    = a_ex_q;
  assign bus_b_o    = b_ex_q;
  assign bus_d_o    = bus_d;
  assign valid_ex_o = valid_ex_q;
  assign v_o        = v_q;
  assign z_o        = z_q;
  assign n_o        = n_q;
  assign c_o        = c_q;

endmodule
